// File: rtl/lsu_align.sv
// Load/store alignment unit in front of a 32-bit word memory: lane select, sign/zero extension, RMW merge.
// Build option: define LSU_MISALIGN_TRAP_EN to report misaligned H/W accesses as errors instead of aligning them.
module lsu_align #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-3:0] dm_addr,
  output logic [31:0]       dm_wd,
  output logic              dm_we,
  input  logic [31:0]       dm_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_reg, state_next;
  logic                latch_en;
  logic                we_reg;
  logic [2:0]          funct3_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [31:0]         wdata_reg;
  logic [31:0]         resp_rdata_reg, resp_rdata_next;
  logic                resp_err_reg, resp_err_next;

  logic [1:0]          size;
  logic                is_unsigned;
  logic                funct3_ok;
  logic                access_ok;
  logic [1:0]          lane;
  logic [31:0]         shifted;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_ext;
  logic [31:0]         st_data;
  logic [3:0]          lane_en;

  // FSM next state
  always_comb begin
    state_next = state_reg;
    latch_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next = ACCESS;
          latch_en   = 1'b1;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign size        = funct3_reg[1:0];
  assign is_unsigned = funct3_reg[2];
  // Stores accept only B/H/W; loads additionally accept BU/HU
  assign funct3_ok   = we_reg ? (!funct3_reg[2] && size != 2'b11)
                              : (size != 2'b11 && !(funct3_reg[2] && size == 2'b10));

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (size == 2'b01 && addr_reg[0]) ||
                      (size == 2'b10 && addr_reg[1:0] != 2'b00);
  assign access_ok  = funct3_ok && !misaligned;
  assign lane       = addr_reg[1:0];
`else
  assign access_ok  = funct3_ok;
  // Drop the low address bits that would break natural alignment
  assign lane       = (size == 2'b01) ? {addr_reg[1], 1'b0} :
                      (size == 2'b10) ? 2'b00 : addr_reg[1:0];
`endif

  assign shifted = dm_rd >> {lane, 3'b000};
  assign ld_byte = shifted[7:0];
  assign ld_half = shifted[15:0];

  always_comb begin
    ld_ext = dm_rd;
    case (size)
      2'b00:   ld_ext = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~is_unsigned & ld_half[15]}}, ld_half};
      default: ld_ext = dm_rd;
    endcase
  end

  // Replicate the store operand so every candidate lane already holds the right bytes
  assign st_data = (size == 2'b00) ? {4{wdata_reg[7:0]}} :
                   (size == 2'b01) ? {2{wdata_reg[15:0]}} : wdata_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_en[gi] = (size == 2'b10) ||
                           (size == 2'b01 && lane[1] == 1'(gi / 2)) ||
                           (size == 2'b00 && lane == 2'(gi));
      assign dm_wd[gi*8 +: 8] = lane_en[gi] ? st_data[gi*8 +: 8] : dm_rd[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    resp_rdata_next = resp_rdata_reg;
    resp_err_next   = resp_err_reg;
    if (state_reg == ACCESS) begin
      resp_err_next   = !access_ok;
      resp_rdata_next = (!we_reg && access_ok) ? ld_ext : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      we_reg         <= 1'b0;
      funct3_reg     <= 3'b000;
      addr_reg       <= '0;
      wdata_reg      <= 32'h0;
      resp_rdata_reg <= 32'h0;
      resp_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      resp_rdata_reg <= resp_rdata_next;
      resp_err_reg   <= resp_err_next;
      if (latch_en) begin
        we_reg     <= req_we;
        funct3_reg <= req_funct3;
        addr_reg   <= req_addr;
        wdata_reg  <= req_wdata;
      end
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;
  assign dm_addr    = addr_reg[ADDR_W-1:2];
  // Gated with rst_n so a reset landing on ACCESS cannot corrupt memory
  assign dm_we      = (state_reg == ACCESS) && we_reg && access_ok && rst_n;

endmodule

// File: tb/tb_lsu_align.sv
// Testbench for lsu_align: directed cases plus random traffic against a byte-level reference memory model.
// Honours LSU_MISALIGN_TRAP_EN the same way as the design build.
module tb_lsu_align;

  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-3:0] dm_addr;
  logic [31:0]       dm_wd;
  logic              dm_we;
  logic [31:0]       dm_rd;

  lsu_align #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_we(dm_we), .dm_rd(dm_rd)
  );

  always #5 clk = ~clk;

  // Data memory: async read, sync write, plus a bench-side preload port
  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [31:0] pre_data;
  int          we_cnt = 0;

  assign dm_rd = mem[dm_addr];

  always @(posedge clk) begin
    if (dm_we) begin
      mem[dm_addr] <= dm_wd;
      we_cnt       <= we_cnt + 1;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = 5'(a);
    pre_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Reference: works on whole bytes of the address space, independent of any lane logic
  function automatic void model(input bit we, input bit [2:0] f3, input bit [6:0] addr,
                                input bit [31:0] wd, output bit [31:0] rd,
                                output bit err, output bit wr);
    int nbytes, a, w, off;
    bit legal, mis;
    bit [31:0] v;
    nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal  = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis    = (int'(addr) % nbytes) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) legal = 1'b0;
`else
    if (mis) legal = legal;
`endif
    rd = 32'h0; err = !legal; wr = 1'b0;
    if (!legal) return;
    a   = int'(addr) - (int'(addr) % nbytes);
    w   = a / 4;
    off = a % 4;
    if (we) begin
      for (int k = 0; k < nbytes; k++) ref_mem[w][8*(off+k) +: 8] = wd[8*k +: 8];
      wr = 1'b1;
    end else begin
      v = ref_mem[w] >> (8 * off);
      if (nbytes == 1) begin
        v = v & 32'hFF;
        if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
      end else if (nbytes == 2) begin
        v = v & 32'hFFFF;
        if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
      end
      rd = v;
    end
  endfunction

  task automatic do_req(input bit we, input bit [2:0] f3, input bit [6:0] addr,
                        input bit [31:0] wd, output bit [31:0] rd, output bit err);
    bit [31:0] exp_rd;
    bit exp_err, exp_wr;
    int wait_cnt, lat, we0;
    model(we, f3, addr, wd, exp_rd, exp_err, exp_wr);
    @(negedge clk);
    wait_cnt = 0;
    while (!req_ready && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("ready_wait", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    we0        = we_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd2);
    rd  = resp_rdata;
    err = resp_err;
    check("rdata", resp_rdata, exp_rd);
    check("err", 32'(resp_err), 32'(exp_err));
    check("writes", 32'(we_cnt - we0), 32'(exp_wr));
    check("mem", mem[addr[6:2]], ref_mem[addr[6:2]]);
    $display("txn we=%0d f3=%0d addr=%h wdata=%h rdata=%h err=%0d", we, f3, addr, wd, rd, err);
    @(negedge clk);
    check("resp_pulse", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    bit [31:0] rd;
    bit err;
    int we0, seen;
    int acc_idx[$];

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = 32'h0; pre_we = 1'b0; pre_addr = 5'd0; pre_data = 32'h0;
    for (int i = 0; i < 32; i++) preload(i, $urandom);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_dm_we", 32'(dm_we), 32'd0);
    check("rst_dm_addr", 32'(dm_addr), 32'd0);

    preload(3, 32'h8899AABB);
    do_req(1'b1, 3'd0, 7'h0D, 32'h123456FF, rd, err);
    check("sb_mem", mem[3], 32'h8899FFBB);
    check("sb_err", 32'(err), 32'd0);
    check("sb_rdata", rd, 32'h0);

    preload(3, 32'h8899AABB);
    do_req(1'b0, 3'd0, 7'h0E, 32'h0, rd, err); check("lb", rd, 32'hFFFFFF99);
    do_req(1'b0, 3'd4, 7'h0E, 32'h0, rd, err); check("lbu", rd, 32'h00000099);
    do_req(1'b0, 3'd1, 7'h0E, 32'h0, rd, err); check("lh", rd, 32'hFFFF8899);
    do_req(1'b0, 3'd5, 7'h0E, 32'h0, rd, err); check("lhu", rd, 32'h00008899);
    do_req(1'b0, 3'd2, 7'h0C, 32'h0, rd, err); check("lw", rd, 32'h8899AABB);

    preload(7, 32'h0);
    do_req(1'b1, 3'd1, 7'h1E, 32'h0000CAFE, rd, err); check("sh_mem", mem[7], 32'hCAFE0000);
    do_req(1'b1, 3'd2, 7'h7C, 32'hDEADBEEF, rd, err); check("sw_mem", mem[31], 32'hDEADBEEF);

    preload(3, 32'h8899AABB);
    do_req(1'b1, 3'd2, 7'h0D, 32'h11223344, rd, err);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_err", 32'(err), 32'd1);
    check("mis_mem", mem[3], 32'h8899AABB);
`else
    check("mis_err", 32'(err), 32'd0);
    check("mis_mem", mem[3], 32'h11223344);
`endif

    do_req(1'b0, 3'd3, 7'h0C, 32'h0, rd, err);
    check("ill_ld_err", 32'(err), 32'd1);
    check("ill_ld_rdata", rd, 32'h0);
    do_req(1'b1, 3'd4, 7'h0C, 32'hFFFFFFFF, rd, err);
    check("ill_st_err", 32'(err), 32'd1);

    // Reset while the store sits in ACCESS
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 7'h0C; req_wdata = 32'hFFFFFFFF;
    we0 = we_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstacc_ready", 32'(req_ready), 32'd1);
    check("rstacc_dm_addr", 32'(dm_addr), 32'd0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    check("rstacc_no_resp", 32'(seen), 32'd0);
    check("rstacc_writes", 32'(we_cnt - we0), 32'd0);
    check("rstacc_mem", mem[3], ref_mem[3]);
    $display("txn reset-during-access sw addr=0c writes=%0d", we_cnt - we0);

    // Back-to-back: valid held high, note cycles where the request is taken
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 7'h0C;
    for (int i = 0; i < 12; i++) begin
      if (req_ready) acc_idx.push_back(i);
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_count", 32'(acc_idx.size()), 32'd4);
    for (int k = 1; k < acc_idx.size(); k++)
      check("b2b_gap", 32'(acc_idx[k] - acc_idx[k-1]), 32'd3);
    $display("txn back-to-back accepts=%0d", acc_idx.size());

    for (int n = 0; n < 200; n++) begin
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             7'($urandom_range(0, 127)), $urandom, rd, err);
    end

    for (int i = 0; i < 32; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
